// File: rtl/bus_arbiter.sv
// Two-master, one-device bus arbiter.
// Masters 0 and 1 share one device bus. Simultaneous requests are served
// round-robin. The device can hold an access with wait states, and an
// access that waits too long is aborted with an error flag.
// Every output comes straight from a flop.

module bus_arbiter #(
    parameter int TIMEOUT = 15          // BUSY cycles without s_rdy before abort (1..255)
) (
    input  logic        clk,
    input  logic        rst,

    // master 0 (CPU bridge)
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [29:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wd,
    output logic [31:0] m0_rd,
    output logic        m0_ack,
    output logic        m0_err,

    // master 1 (DMA / debug)
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [29:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wd,
    output logic [31:0] m1_rd,
    output logic        m1_ack,
    output logic        m1_err,

    // shared device bus
    output logic        s_sel,
    output logic        s_we,
    output logic [29:0] s_addr,
    output logic [3:0]  s_be,
    output logic [31:0] s_wd,
    input  logic [31:0] s_rd,
    input  logic        s_rdy
);

    // Counter value at which a still-waiting access is aborted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Arbitration bookkeeping: who owns the current access, who was served last.
    logic        gnt_q, gnt_d;
    logic        last_grant_q, last_grant_d;
    logic        pick;

    // Wait-state counter for the timeout.
    logic [7:0]  cnt_q, cnt_d;

    // Device-side registers.
    logic        s_sel_q, s_sel_d;
    logic        s_we_q, s_we_d;
    logic [29:0] s_addr_q, s_addr_d;
    logic [3:0]  s_be_q, s_be_d;
    logic [31:0] s_wd_q, s_wd_d;

    // Master-side response registers.
    logic [31:0] m0_rd_q, m0_rd_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m0_err_q, m0_err_d;
    logic [31:0] m1_rd_q, m1_rd_d;
    logic        m1_ack_q, m1_ack_d;
    logic        m1_err_q, m1_err_d;

    // Winner of arbitration in IDLE: the sole requester, or on a tie the
    // master that was not served last.
    always_comb begin
        if (m0_req && m1_req) begin
            pick = ~last_grant_q;
        end else begin
            pick = m1_req;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        // NOTE: every _d starts from a hold or idle default so that no path
        // through the case leaves a signal unassigned (which would infer a latch).
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        s_sel_d      = s_sel_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_be_d       = s_be_q;
        s_wd_d       = s_wd_q;
        m0_rd_d      = m0_rd_q;
        m0_err_d     = m0_err_q;
        m0_ack_d     = 1'b0;
        m1_rd_d      = m1_rd_q;
        m1_err_d     = m1_err_q;
        m1_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    cnt_d        = 8'd0;
                    s_sel_d      = 1'b1;
                    if (pick) begin
                        s_we_d   = m1_we;
                        s_addr_d = m1_addr;
                        s_be_d   = m1_be;
                        s_wd_d   = m1_wd;
                    end else begin
                        s_we_d   = m0_we;
                        s_addr_d = m0_addr;
                        s_be_d   = m0_be;
                        s_wd_d   = m0_wd;
                    end
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (s_rdy) begin
                    // Completion wins even on the cycle the timeout would fire.
                    s_sel_d = 1'b0;
                    s_we_d  = 1'b0;
                    if (gnt_q) begin
                        m1_rd_d  = s_rd;
                        m1_err_d = 1'b0;
                        m1_ack_d = 1'b1;
                    end else begin
                        m0_rd_d  = s_rd;
                        m0_err_d = 1'b0;
                        m0_ack_d = 1'b1;
                    end
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Device never answered: abandon and report an error.
                    s_sel_d = 1'b0;
                    s_we_d  = 1'b0;
                    if (gnt_q) begin
                        m1_rd_d  = 32'd0;
                        m1_err_d = 1'b1;
                        m1_ack_d = 1'b1;
                    end else begin
                        m0_rd_d  = 32'd0;
                        m0_err_d = 1'b1;
                        m0_ack_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RESP: begin
                // The ack pulse is on the flops this cycle; it drops on the way out.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset is synchronous and beats every other event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge, independent of statement order.
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;       // m0 wins the first tie after reset
            cnt_q        <= 8'd0;
            s_sel_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= 30'd0;
            s_be_q       <= 4'd0;
            s_wd_q       <= 32'd0;
            m0_rd_q      <= 32'd0;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_rd_q      <= 32'd0;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            s_sel_q      <= s_sel_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_be_q       <= s_be_d;
            s_wd_q       <= s_wd_d;
            m0_rd_q      <= m0_rd_d;
            m0_ack_q     <= m0_ack_d;
            m0_err_q     <= m0_err_d;
            m1_rd_q      <= m1_rd_d;
            m1_ack_q     <= m1_ack_d;
            m1_err_q     <= m1_err_d;
        end
    end

    assign s_sel  = s_sel_q;
    assign s_we   = s_we_q;
    assign s_addr = s_addr_q;
    assign s_be   = s_be_q;
    assign s_wd   = s_wd_q;
    assign m0_rd  = m0_rd_q;
    assign m0_ack = m0_ack_q;
    assign m0_err = m0_err_q;
    assign m1_rd  = m1_rd_q;
    assign m1_ack = m1_ack_q;
    assign m1_err = m1_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Inputs are driven, and outputs
// sampled, 1 time unit after each rising edge.

module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we;
    logic [29:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wd, m0_rd;
    logic        m0_ack, m0_err;
    logic        m1_req, m1_we;
    logic [29:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wd, m1_rd;
    logic        m1_ack, m1_err;
    logic        s_sel, s_we;
    logic [29:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd, s_rd;
    logic        s_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [29:0] ADDR_A = 30'h1FC0_0002;
    localparam logic [29:0] ADDR_B = 30'h0123_4567;
    localparam logic [29:0] ADDR_C = 30'h0000_0040;

    bus_arbiter #(.TIMEOUT(15)) dut (
        .clk    (clk),
        .rst    (rst),
        .m0_req (m0_req),
        .m0_we  (m0_we),
        .m0_addr(m0_addr),
        .m0_be  (m0_be),
        .m0_wd  (m0_wd),
        .m0_rd  (m0_rd),
        .m0_ack (m0_ack),
        .m0_err (m0_err),
        .m1_req (m1_req),
        .m1_we  (m1_we),
        .m1_addr(m1_addr),
        .m1_be  (m1_be),
        .m1_wd  (m1_wd),
        .m1_rd  (m1_rd),
        .m1_ack (m1_ack),
        .m1_err (m1_err),
        .s_sel  (s_sel),
        .s_we   (s_we),
        .s_addr (s_addr),
        .s_be   (s_be),
        .s_wd   (s_wd),
        .s_rd   (s_rd),
        .s_rdy  (s_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " s_sel"},  {31'd0, s_sel},  32'd0);
        check({tag, " s_we"},   {31'd0, s_we},   32'd0);
        check({tag, " s_addr"}, {2'd0, s_addr},  32'd0);
        check({tag, " s_be"},   {28'd0, s_be},   32'd0);
        check({tag, " s_wd"},   s_wd,            32'd0);
        check({tag, " m0_ack"}, {31'd0, m0_ack}, 32'd0);
        check({tag, " m1_ack"}, {31'd0, m1_ack}, 32'd0);
        check({tag, " m0_err"}, {31'd0, m0_err}, 32'd0);
        check({tag, " m1_err"}, {31'd0, m1_err}, 32'd0);
        check({tag, " m0_rd"},  m0_rd,           32'd0);
        check({tag, " m1_rd"},  m1_rd,           32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int          n_sel;
        logic [7:0]  exp_sel;
        logic [7:0]  exp_a0;
        logic [7:0]  exp_a1;

        rst     = 1'b1;
        m0_req  = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = '0; m0_wd = '0;
        m1_req  = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = '0; m1_wd = '0;
        s_rd    = '0;   s_rdy = 1'b0;

        // ---- reset state
        do_reset();
        check_reset_values("reset");

        // ---- single read, zero-wait device
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = ADDR_A; m0_be = 4'hF;
        s_rdy  = 1'b1; s_rd = 32'hDEAD_BEEF;
        tick();                                   // grant edge
        check("rd1 s_sel busy", {31'd0, s_sel}, 32'd1);
        check("rd1 s_addr", {2'd0, s_addr}, {2'd0, ADDR_A});
        check("rd1 s_we", {31'd0, s_we}, 32'd0);
        check("rd1 no ack yet", {31'd0, m0_ack}, 32'd0);
        tick();                                   // s_rdy seen
        check("rd1 s_sel drop", {31'd0, s_sel}, 32'd0);
        check("rd1 m0_ack", {31'd0, m0_ack}, 32'd1);
        check("rd1 m1_ack", {31'd0, m1_ack}, 32'd0);
        check("rd1 m0_rd", m0_rd, 32'hDEAD_BEEF);
        check("rd1 m0_err", {31'd0, m0_err}, 32'd0);
        m0_req = 1'b0; s_rdy = 1'b0;
        tick();
        check("rd1 ack one cycle", {31'd0, m0_ack}, 32'd0);
        check("rd1 m0_rd held", m0_rd, 32'hDEAD_BEEF);

        // ---- tie after reset: grants m0, m1, m0; acks 3 cycles apart
        do_reset();
        m0_req = 1'b1; m0_addr = ADDR_A;
        m1_req = 1'b1; m1_addr = ADDR_B; m1_we = 1'b0; m1_be = 4'hF;
        s_rdy  = 1'b1; s_rd = 32'hCAFE_0001;
        exp_sel = 8'b0100_1001;
        exp_a0  = 8'b1000_0010;
        exp_a1  = 8'b0001_0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("tie c%0d s_sel", i + 1), {31'd0, s_sel}, {31'd0, exp_sel[i]});
            check($sformatf("tie c%0d m0_ack", i + 1), {31'd0, m0_ack}, {31'd0, exp_a0[i]});
            check($sformatf("tie c%0d m1_ack", i + 1), {31'd0, m1_ack}, {31'd0, exp_a1[i]});
            if (i == 0 || i == 6) check($sformatf("tie c%0d addr m0", i + 1), {2'd0, s_addr}, {2'd0, ADDR_A});
            if (i == 3)           check("tie c4 addr m1", {2'd0, s_addr}, {2'd0, ADDR_B});
            if (i == 4)           check("tie m1_rd", m1_rd, 32'hCAFE_0001);
        end
        m0_req = 1'b0; m1_req = 1'b0; s_rdy = 1'b0;
        tick();
        check("tie idle after", {31'd0, s_sel}, 32'd0);

        // ---- m1 write with wait states
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = ADDR_C; m1_be = 4'b0011; m1_wd = 32'h0000_1234;
        s_rdy  = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("ws c%0d s_sel", i), {31'd0, s_sel}, 32'd1);
            check($sformatf("ws c%0d s_we", i), {31'd0, s_we}, 32'd1);
            check($sformatf("ws c%0d s_addr", i), {2'd0, s_addr}, {2'd0, ADDR_C});
            check($sformatf("ws c%0d s_be", i), {28'd0, s_be}, 32'h3);
            check($sformatf("ws c%0d s_wd", i), s_wd, 32'h0000_1234);
            check($sformatf("ws c%0d m1_ack", i), {31'd0, m1_ack}, 32'd0);
            if (i == 5) begin
                s_rdy = 1'b1; s_rd = 32'h5555_AAAA;
            end
            tick();
        end
        check("ws m1_ack", {31'd0, m1_ack}, 32'd1);
        check("ws m1_err", {31'd0, m1_err}, 32'd0);
        check("ws m1_rd", m1_rd, 32'h5555_AAAA);
        check("ws s_sel drop", {31'd0, s_sel}, 32'd0);
        check("ws s_we drop", {31'd0, s_we}, 32'd0);
        m1_req = 1'b0; m1_we = 1'b0; s_rdy = 1'b0;
        tick();

        // ---- timeout with device silent
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = ADDR_A;
        tick();
        n_sel = 0;
        while (s_sel && n_sel < 40) begin
            n_sel++;
            tick();
        end
        check("to s_sel cycles", n_sel, 32'd15);
        check("to m0_ack", {31'd0, m0_ack}, 32'd1);
        check("to m0_err", {31'd0, m0_err}, 32'd1);
        check("to m0_rd zero", m0_rd, 32'd0);
        m0_req = 1'b0;
        tick();
        check("to ack drop", {31'd0, m0_ack}, 32'd0);
        check("to err held", {31'd0, m0_err}, 32'd1);

        // ---- s_rdy on the expiry cycle counts as success
        m0_req = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to15 c%0d s_sel", i), {31'd0, s_sel}, 32'd1);
            if (i == 15) begin
                s_rdy = 1'b1; s_rd = 32'h0BAD_F00D;
            end
            tick();
        end
        check("to15 m0_ack", {31'd0, m0_ack}, 32'd1);
        check("to15 m0_err", {31'd0, m0_err}, 32'd0);
        check("to15 m0_rd", m0_rd, 32'h0BAD_F00D);
        m0_req = 1'b0; s_rdy = 1'b0;
        tick();

        // ---- reset during the 3rd BUSY cycle of an m0 access
        m0_req = 1'b1; m0_addr = ADDR_A;
        tick();                                   // BUSY 1
        tick();                                   // BUSY 2
        tick();                                   // BUSY 3
        check("rmid busy", {31'd0, s_sel}, 32'd1);
        rst = 1'b1; m1_req = 1'b1; m1_addr = ADDR_B;
        tick();
        check_reset_values("rmid");
        rst = 1'b0;
        tick();                                   // both requesting, m0 must win
        check("rmid regrant sel", {31'd0, s_sel}, 32'd1);
        check("rmid regrant m0", {2'd0, s_addr}, {2'd0, ADDR_A});
        s_rdy = 1'b1; s_rd = 32'h1357_9BDF;
        tick();
        check("rmid m0_ack", {31'd0, m0_ack}, 32'd1);
        check("rmid m1_ack", {31'd0, m1_ack}, 32'd0);
        m0_req = 1'b0; m1_req = 1'b0; s_rdy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 15, number of BUSY cycles without s_rdy before an access is aborted (legal range 1..255).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_req  input  1  master 0 (CPU bridge) access request, level.
REQ-005 m0_we  input  1  master 0 write enable.
REQ-006 m0_addr  input  30  master 0 word address [31:2].
REQ-007 m0_be  input  4  master 0 byte enables.
REQ-008 m0_wd  input  32  master 0 write data.
REQ-009 m0_rd  output  32  master 0 read data, valid while m0_ack=1.
REQ-010 m0_ack  output  1  master 0 completion pulse.
REQ-011 m0_err  output  1  master 0 timeout flag, valid while m0_ack=1.
REQ-012 m1_req, m1_we, m1_addr, m1_be, m1_wd, m1_rd, m1_ack, m1_err: same directions, widths and meanings as m0_*, for master 1 (DMA/debug).
REQ-013 s_sel  output  1  shared device bus select.
REQ-014 s_we  output  1  device write enable.
REQ-015 s_addr  output  30  device word address.
REQ-016 s_be  output  4  device byte enables.
REQ-017 s_wd  output  32  device write data.
REQ-018 s_rd  input  32  device read data, valid when s_rdy=1.
REQ-019 s_rdy  input  1  device completion, sampled only while s_sel=1.

Function
REQ-020 State machine states: IDLE, BUSY, RESP; all outputs registered.
REQ-021 IDLE: if no request, stay; if exactly one mN_req=1, grant N; if both, grant the master not served last (round-robin via last_grant bit).
REQ-022 On grant edge: latch that master's we/addr/be/wd into s_*, set s_sel=1, clear timeout counter, update last_grant, go BUSY.
REQ-023 BUSY: s_* held constant; at edge with s_rdy=1, capture s_rd into granted mN_rd, drop s_sel and s_we, go RESP.
REQ-024 BUSY: counter increments each cycle s_rdy=0; at edge where counter reaches TIMEOUT-1 with s_rdy=0, drop s_sel/s_we, set mN_rd=0, mN_err=1, go RESP.
REQ-025 s_rdy=1 on the same edge as timeout expiry counts as success (err=0).
REQ-026 RESP: granted mN_ack=1 for exactly one cycle, other master's ack=0; then go IDLE unconditionally.
REQ-027 Latency: request seen in IDLE at edge k -> s_sel=1 in cycle k+1; s_rdy at edge j -> ack in cycle j+1; minimum request-to-ack 2 cycles, zero-wait device.
REQ-028 Masters hold req and all request fields stable until ack and deassert req at the edge ending the ack cycle; a req still high in IDLE is a new request.
REQ-029 Non-granted master's request is ignored (not latched) until arbiter returns to IDLE; it is not lost while its req stays high.
REQ-030 mN_rd and mN_err retain last value outside ack; only the granted master's registers update.
REQ-031 Writes: mN_rd set to s_rd sample regardless (don't-care to master); err semantics identical to reads.
REQ-032 Back-to-back: both masters continuously requesting alternate grants m0, m1, m0, ... each access min 3 cycles (IDLE, BUSY, RESP).

Reset
REQ-033 rst=1 at an edge forces IDLE from any state, including mid-BUSY (device access abandoned without ack).
REQ-034 Reset values: s_sel=0, s_we=0, s_addr=0, s_be=0, s_wd=0, m0_ack=m1_ack=0, m0_err=m1_err=0, m0_rd=m1_rd=0, counter=0.
REQ-035 Reset sets last_grant=1 so m0 wins the first simultaneous request.
REQ-036 rst has priority over every other event in the same cycle.

Verification
REQ-037 Single read: m0_req=1, addr=0x1FC0_0002 (word), device s_rdy=1 first BUSY cycle, s_rd=0xDEADBEEF -> s_sel high 1 cycle, m0_ack pulse 2 cycles after req, m0_rd=0xDEADBEEF, m0_err=0.
REQ-038 Tie after reset: m0_req=m1_req=1 simultaneously, zero-wait device, both held -> grant order m0, m1, m0; acks 3 cycles apart.
REQ-039 Wait states: m1 write be=4'b0011 wd=0x0000_1234, s_rdy asserted after 5 BUSY cycles -> s_* stable all 5 cycles, s_we=1, m1_ack one cycle after s_rdy, m1_err=0.
REQ-040 Timeout: TIMEOUT=15, s_rdy held 0 -> s_sel high exactly 15 cycles, then m0_ack=1, m0_err=1, m0_rd=0; s_rdy=1 in 15th cycle -> err=0.
REQ-041 Reset mid-op: rst=1 in 3rd BUSY cycle -> next cycle all outputs at reset values, no ack; after release with both req high, m0 granted first.
